// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, multi-cycle
// results wait in a small FIFO, and a per-register scoreboard drives decode hazards.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_wb_en,
    input  logic [ADDR_W-1:0] pipe_wb_dest,
    input  logic [DATA_W-1:0] pipe_wb_value,
    input  logic              mc_issue,
    input  logic [ADDR_W-1:0] mc_issue_dest,
    output logic              mc_issue_stall,
    input  logic              mc_valid,
    input  logic [ADDR_W-1:0] mc_dest,
    input  logic [DATA_W-1:0] mc_value,
    output logic              mc_ready,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    output logic              hazard,
    output logic              writeBackEn,
    output logic [ADDR_W-1:0] dest_wb,
    output logic [DATA_W-1:0] Result_WB,
    output logic [15:0]       defer_cnt,
    output logic              err
);
    localparam int NREG = 1 << ADDR_W;
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = PW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] value;
    } wb_entry_t;

    wb_entry_t         fifo [DEPTH];
    wb_entry_t         head;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic [NREG-1:0]   pending, pending_nxt;
    logic              empty, push, pop, issue_ok, err_set;

    assign empty          = (count == '0);
    assign mc_ready       = (count < CW'(DEPTH));
    assign head           = fifo[rd_ptr];
    assign push           = mc_valid & mc_ready;
    assign pop            = ~pipe_wb_en & ~empty;
    assign mc_issue_stall = pending[mc_issue_dest];
    assign hazard         = pending[src1] | pending[src2];
    assign issue_ok       = mc_issue & ~mc_issue_stall;
    assign err_set        = (mc_issue & mc_issue_stall)
                          | (push & ~pending[mc_dest])
                          | (pipe_wb_en & pending[pipe_wb_dest]);

    always_comb begin
        writeBackEn = 1'b0;
        dest_wb     = '0;
        Result_WB   = '0;
        if (pipe_wb_en) begin
            writeBackEn = 1'b1;
            dest_wb     = pipe_wb_dest;
            Result_WB   = pipe_wb_value;
        end else if (!empty) begin
            writeBackEn = 1'b1;
            dest_wb     = head.dest;
            Result_WB   = head.value;
        end
    end

    // Clear is applied after set so a same-register collision leaves the bit clear.
    always_comb begin
        pending_nxt = pending;
        if (issue_ok) pending_nxt[mc_issue_dest] = 1'b1;
        if (pop)      pending_nxt[head.dest]     = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= '{dest: mc_dest, value: mc_value};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            pending   <= '0;
            defer_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            pending <= pending_nxt;
            if (pipe_wb_en && !empty && defer_cnt != 16'hFFFF)
                defer_cnt <= defer_cnt + 16'd1;
            if (err_set) err <= 1'b1;
        end
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the 16×32 register file between the in-order pipeline write-back stage and a multi-cycle execution unit (multiplier/divider/memory) that returns results out of step with the pipeline. It also tracks destination registers with outstanding multi-cycle results (scoreboard) and raises a read hazard for the decode stage. The block sits between the WB stage, the multi-cycle unit and the register file write port (`writeBackEn`/`dest_wb`/`Result_WB`).

## Interface
- `DATA_W`, 32, write data width
- `ADDR_W`, 4, register address width (16 registers)
- `DEPTH`, 2, multi-cycle result buffer entries (power of 2, ≥2)
- `clk` in 1 — clock; all state updates on posedge
- `rst` in 1 — reset, asynchronous, active-high
- `pipe_wb_en` in 1 — pipeline write-back valid this cycle (cannot be stalled)
- `pipe_wb_dest` in ADDR_W — pipeline destination
- `pipe_wb_value` in DATA_W — pipeline result
- `mc_issue` in 1 — multi-cycle op issued this cycle
- `mc_issue_dest` in ADDR_W — its destination register
- `mc_issue_stall` out 1 — `pending[mc_issue_dest]`, combinational
- `mc_valid` in 1 — multi-cycle result offered
- `mc_dest` in ADDR_W, `mc_value` in DATA_W — offered result
- `mc_ready` out 1 — buffer not full
- `src1`, `src2` in ADDR_W — decode-stage read addresses
- `hazard` out 1 — `pending[src1] | pending[src2]`, combinational
- `writeBackEn` out 1, `dest_wb` out ADDR_W, `Result_WB` out DATA_W — register file write port
- `defer_cnt` out 16 — saturating count of cycles the buffer head was blocked by the pipeline
- `err` out 1 — sticky protocol error

## Operation
- State: `pending[15:0]`, FIFO of DEPTH {dest,value} entries with rd/wr pointers and count, `defer_cnt`, `err`.
- Write-port mux (combinational): `pipe_wb_en`=1 → forward pipe dest/value, `writeBackEn`=1. Else FIFO non-empty → forward head, `writeBackEn`=1, pop at posedge. Else `writeBackEn`=0, dest/value=0.
- Pipeline always has priority; FIFO head is never dropped, only deferred.
- Push: `mc_valid & mc_ready` at posedge writes {mc_dest, mc_value} at tail. No bypass: an accepted result is never written in its acceptance cycle.
- Push and pop in the same cycle allowed (count unchanged), including when count = DEPTH−1 or when DEPTH entries would be exceeded only transiently; `mc_ready` = (count < DEPTH), derived from registered count only.
- Pointers wrap modulo DEPTH.
- Scoreboard: `mc_issue & ~mc_issue_stall` sets `pending[mc_issue_dest]`. An issue while stalled is dropped and sets `err`.
- Pop of head entry with dest r clears `pending[r]`. Clear and set of different registers in the same cycle both take effect. Same register: `mc_issue_stall` is high, so the issue is dropped (clear wins, `err` set).
- `err` is also set by: push with `pending[mc_dest]`=0; `pipe_wb_en` with `pending[pipe_wb_dest]`=1 (write still performed).
- `defer_cnt` increments when `pipe_wb_en` and FIFO non-empty; saturates at 0xFFFF.
- `err` clears only on `rst`.

## Timing
- Reset values: `pending`=0, FIFO empty, `mc_ready`=1, `writeBackEn`=0, `dest_wb`=0, `Result_WB`=0, `hazard`=0, `mc_issue_stall`=0, `defer_cnt`=0, `err`=0.
- Reset mid-operation discards buffered results and pending bits immediately (asynchronous).
- Write-port outputs are combinational within the cycle; the register file samples them on the following negedge.
- Minimum latency: result accepted at posedge N is presented during cycle N+1 and written at that cycle's negedge; `pending` clears at posedge N+2 edge boundary (end of cycle N+1).
- `hazard` drops in the cycle after the write is committed.

## Test plan
- Reset then idle: all outputs at reset values, `mc_ready`=1, `err`=0.
- Issue r5, accept {r5, 0xDEADBEEF} with `pipe_wb_en`=0 → next cycle `writeBackEn`=1, `dest_wb`=5, `Result_WB`=0xDEADBEEF; `hazard` with `src1`=5 high until write cycle ends, then 0.
- Issue r3,r4; accept both; hold `pipe_wb_en`=1 for 3 cycles → `mc_ready`=0, FIFO held, `defer_cnt`=3; then r3 and r4 drain in order on two consecutive cycles.
- Full FIFO with simultaneous pop and `mc_valid` → no push while `mc_ready`=0; push accepted next cycle; no entry lost or duplicated.
- Issue r7 while r7 pending → issue dropped, `err`=1; `pipe_wb_en` to pending r2 → write occurs, `err`=1.
- Assert `rst` with 2 buffered entries → FIFO empty, `pending`=0, `writeBackEn`=0 immediately; stays cleared after release.
